// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the fetch PC, issues in-order word requests and buffers {pc, inst} pairs for decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the prefetch FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    // Stale responses can pile up across back-to-back redirects, so drop gets headroom.
    localparam int DROP_W = CNT_W + 4;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       fifo_pc_q   [DEPTH];
    logic [31:0]       fifo_inst_q [DEPTH];
    logic [31:0]       tag_pc_q    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CNT_W-1:0]  count_q, count_d, outstanding_q, outstanding_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic credit_ok, req_fire, rsp_live, rsp_stale, fifo_empty;
    logic push, pop, byp_valid;

    // Credits use only registered counts, keeping if_ready out of the request path.
    assign credit_ok      = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C;
    assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (drop_q == '0);
    assign rsp_stale      = imem_rsp_valid && (drop_q != '0);
    assign fifo_empty     = (count_q == '0);
    assign pop            = !redirect_valid && !fifo_empty && if_ready;

`ifdef FETCH_BYPASS_EN
    assign byp_valid = rst_n && fifo_empty && rsp_live && !redirect_valid;
`else
    assign byp_valid = 1'b0;
`endif

    assign push = rsp_live && !redirect_valid && !(byp_valid && if_ready);

    always_comb begin
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        if (rst_n && !fifo_empty) begin
            if_valid = 1'b1;
            if_pc    = fifo_pc_q[rd_ptr_q];
            if_inst  = fifo_inst_q[rd_ptr_q];
        end else if (byp_valid) begin
            if_valid = 1'b1;
            if_pc    = tag_pc_q[tag_rd_q];
            if_inst  = imem_rsp_data;
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path infers a latch.
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect_valid) begin
            // Every live request in flight becomes stale; a response this cycle retires one of them.
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            tag_rd_d      = '0;
            tag_wr_d      = '0;
            count_d       = '0;
            outstanding_d = '0;
            drop_d        = drop_q + DROP_W'(outstanding_q) - DROP_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tag_wr_d   = tag_wr_q + PTR_W'(1);
            end
            if (rsp_live)  tag_rd_d = tag_rd_q + PTR_W'(1);
            if (rsp_stale) drop_d   = drop_q - DROP_W'(1);
            if (push)      wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // NOTE: storage arrays are not reset; the counters alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= tag_pc_q[tag_rd_q];
            fifo_inst_q[wr_ptr_q] <= imem_rsp_data;
        end
        if (req_fire) tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end

endmodule
